serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
//
// PURPOSE
//   Bit-serial adder controller that time-shares a single 1-bit adder slice.
//   The slice is two half adders plus an OR for carry-out.
//   Accepts WIDTH-bit operands on a start request and sequences the slice LSB-first, one bit per clock.
//   Accumulates the sum and carry, then reports the result with a one-cycle done pulse.
//   Sits between a requester (FSM/testbench) and the shared adder slice; trades latency for area.
//
// PARAMETERS
//   WIDTH   8   operand/sum width in bits (>=2); bit counter sized $clog2(WIDTH+1)
//
// PORTS
//   clk     input   1      single clock; all state updates on rising edge
//   rst     input   1      asynchronous, active-high reset
//   start   input   1      request; sampled only in IDLE
//   a       input   WIDTH  operand A; captured on the start-accept edge only
//   b       input   WIDTH  operand B; captured on the start-accept edge only
//   busy    output  1      1 while in RUN
//   done    output  1      1 for exactly one cycle (DONE state) when result valid
//   sum     output  WIDTH  registered result; holds until next completion
//   cout    output  1      registered carry-out; holds until next completion
//
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, count=0, shift regs=0.
//     Takes effect immediately, incl. mid-RUN; in-flight operation discarded, no done pulse.
//   - States: IDLE, RUN, DONE (registered); busy=(state==RUN), done=(state==DONE), both decoded from state reg.
//   - IDLE: start=1 at edge E0 -> load sa<=a, sb<=b, carry<=0, count<=0, state<=RUN. start=0 -> stay.
//   - RUN, each edge Ek (k=1..WIDTH): slice inputs sa[0], sb[0], carry.
//       ha1: p=sa[0]^sb[0], g1=sa[0]&sb[0]; ha2: s=p^carry, g2=p&carry; carry<=g1|g2.
//       res<={s,res[WIDTH-1:1]} (shift in at MSB); sa,sb shift right by 1; count<=count+1.
//       At E_WIDTH (count==WIDTH-1): sum<={s,res[WIDTH-1:1]}, cout<=g1|g2, state<=DONE.
//   - DONE: single cycle; next edge -> IDLE unconditionally.
//   - Latency: start accepted at E0 -> done high from E_WIDTH to E_WIDTH+1.
//     Min start-to-start period WIDTH+2 cycles.
//   - start while RUN or DONE: ignored, no queuing; a/b changes after E0 have no effect on the result.
//   - start held high continuously: next operation accepted at the first IDLE edge after DONE.
//   - sum/cout change only at completion edge or reset; never show partial results.
//   - Arithmetic: {cout,sum} == a+b (unsigned, WIDTH+1 bits), wrap modulo 2^WIDTH in sum.
//   - No X on outputs after reset; unused/idle slice inputs are don't-care but must not alter state.
//
// TESTING (WIDTH=8)
//   1. rst=1 then release; start=0 -> busy=0, done=0, sum=8'h00, cout=0 indefinitely.
//   2. a=8'h0F, b=8'h01, start pulse -> busy high 8 cycles, done 1 cycle at E8, sum=8'h10, cout=0.
//   3. a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1;
//      sum holds 8'h00 until second done.
//   4. start pulsed again at E3 with new a/b mid-RUN -> ignored; result matches first operands; only one done pulse.
//   5. rst asserted asynchronously at E4 (between edges) of an operation -> outputs zero immediately, IDLE, no done;
//      a new op after release completes correctly.
//   6. start held high, random a/b x200 vs reference a+b -> done period exactly 10 cycles, every {cout,sum} correct.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial adder controller. Captures two WIDTH-bit operands on a start
// request, then feeds one 1-bit adder slice (two half adders plus an OR)
// LSB-first, one bit per clock. The result is published in one step when the
// final bit is done, so sum/cout never show partial values. done pulses for
// one cycle in the DONE state.

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Operand shift registers; bit 0 is the bit being added this cycle.
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;

  // Collected sum bits (the final bit arrives on the completion edge, so only
  // WIDTH-1 bits need to be stored beforehand).
  logic [WIDTH-2:0] res;

  logic          carry;
  logic [CW-1:0] count;

  // Slice signals.
  logic             p;
  logic             g1;
  logic             s;
  logic             g2;
  logic             carry_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // Shared 1-bit adder slice: two half adders with the generate terms ORed.
  always_comb begin
    p          = sa[0] ^ sb[0];
    g1         = sa[0] & sb[0];
    s          = p ^ carry;
    g2         = p & carry;
    carry_next = g1 | g2;
    res_next   = {s, res};
    last_bit   = (count == LAST_BIT);
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start is only honoured in IDLE; DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags are plain decodes of the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Datapath: load operands on accept, shift one bit per RUN cycle, and
  // publish sum/cout only on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= 1'b0;
            count <= '0;
          end
        end
        RUN: begin
          carry <= carry_next;
          res   <= res_next[WIDTH-1:1];
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          count <= count + 1'b1;
          if (last_bit) begin
            sum  <= res_next;
            cout <= carry_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
// Directed bench for the bit-serial adder controller (WIDTH=8). Each task
// covers one scenario and checks its own expected values.

module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int vectors;
  int miscompares;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Wait (on falling edges) until done is seen, bounded to 20 cycles.
  task automatic wait_done(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  // Issue a one-cycle start pulse and follow the operation to done.
  task automatic do_op(input logic [7:0] opa, input logic [7:0] opb,
                       output int busy_cnt, output bit ok);
    @(negedge clk);
    a     = opa;
    b     = opb;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    #2;
    vectors++;
    if ({busy, done, cout, sum} !== 11'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, expected all zero",
               busy, done, cout, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done, cout, sum} !== 11'h000) begin
        miscompares++;
        $display("[TB] FAIL idle_after_reset cycle %0d: got busy=%b done=%b cout=%b sum=%h, expected all zero",
                 i, busy, done, cout, sum);
      end
    end
  endtask

  task automatic test_basic();
    int busy_cnt;
    bit ok;
    do_op(8'h0F, 8'h01, busy_cnt, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL basic_done_timeout: done never asserted, expected within 20 cycles");
    end
    vectors++;
    if (busy_cnt !== 8) begin
      miscompares++;
      $display("[TB] FAIL basic_busy_cycles: got %0d, expected 8", busy_cnt);
    end
    vectors++;
    if ({cout, sum} !== 9'h010 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_result: got cout=%b sum=%h busy=%b, expected cout=0 sum=10 busy=0",
               cout, sum, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h10) begin
      miscompares++;
      $display("[TB] FAIL basic_done_width: got done=%b busy=%b sum=%h, expected done=0 busy=0 sum=10",
               done, busy, sum);
    end
  endtask

  task automatic test_overflow();
    int busy_cnt;
    int cycles;
    bit ok;
    do_op(8'hFF, 8'h01, busy_cnt, ok);
    vectors++;
    if (!ok || {cout, sum} !== 9'h100) begin
      miscompares++;
      $display("[TB] FAIL overflow_ff_01: got ok=%b cout=%b sum=%h, expected cout=1 sum=00",
               ok, cout, sum);
    end
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || {cout, sum} !== 9'h100) begin
      miscompares++;
      $display("[TB] FAIL overflow_hold_midrun: got busy=%b cout=%b sum=%h, expected busy=1 cout=1 sum=00",
               busy, cout, sum);
    end
    wait_done(cycles, ok);
    vectors++;
    if (!ok || {cout, sum} !== 9'h1FE) begin
      miscompares++;
      $display("[TB] FAIL overflow_ff_ff: got ok=%b cout=%b sum=%h, expected cout=1 sum=fe",
               ok, cout, sum);
    end
  endtask

  task automatic test_start_ignored();
    int cycles;
    int extra_done;
    bit ok;
    @(negedge clk);
    a     = 8'h3C;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cycles, ok);
    vectors++;
    if (!ok || {cout, sum} !== 9'h091) begin
      miscompares++;
      $display("[TB] FAIL ignored_start_result: got ok=%b cout=%b sum=%h, expected cout=0 sum=91",
               ok, cout, sum);
    end
    extra_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    vectors++;
    if (extra_done !== 0) begin
      miscompares++;
      $display("[TB] FAIL ignored_start_extra_activity: got %0d busy/done cycles, expected 0",
               extra_done);
    end
  endtask

  task automatic test_async_reset();
    int busy_cnt;
    int activity;
    bit ok;
    @(negedge clk);
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, cout, sum} !== 11'h000) begin
      miscompares++;
      $display("[TB] FAIL async_reset_immediate: got busy=%b done=%b cout=%b sum=%h, expected all zero",
               busy, done, cout, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    activity = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy || sum !== 8'h00 || cout !== 1'b0) activity++;
    end
    vectors++;
    if (activity !== 0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_no_done: got %0d non-idle cycles, expected 0", activity);
    end
    do_op(8'h12, 8'h34, busy_cnt, ok);
    vectors++;
    if (!ok || busy_cnt !== 8 || {cout, sum} !== 9'h046) begin
      miscompares++;
      $display("[TB] FAIL async_reset_recover: got ok=%b busy_cnt=%0d cout=%b sum=%h, expected busy_cnt=8 cout=0 sum=46",
               ok, busy_cnt, cout, sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] expected;
    int cycles;
    bit ok;
    @(negedge clk);
    a        = 8'($urandom);
    b        = 8'($urandom);
    expected = {1'b0, a} + {1'b0, b};
    start    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      wait_done(cycles, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("[TB] FAIL b2b_timeout op %0d: done not seen, expected within 20 cycles", i);
        break;
      end
      vectors++;
      if ({cout, sum} !== expected) begin
        miscompares++;
        $display("[TB] FAIL b2b_result op %0d: got %h, expected %h", i, {cout, sum}, expected);
      end
      if (i > 0) begin
        vectors++;
        if (cycles + 1 !== 10) begin
          miscompares++;
          $display("[TB] FAIL b2b_period op %0d: got %0d cycles, expected 10", i, cycles + 1);
        end
      end
      a        = 8'($urandom);
      b        = 8'($urandom);
      expected = {1'b0, a} + {1'b0, b};
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Run every scenario in order, then report.
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
